display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for an N-digit common-anode 7-segment display. It feeds one shared BCD-to-segment decoder (combinational, active-low segments, codes A–F decode to blank). The block latches a multi-digit BCD value, cycles through the digits at a programmable rate with an inter-digit blanking gap to prevent ghosting, and optionally suppresses leading zeros. New values are committed only at frame boundaries so a frame never mixes old and new digits. It sits between the calculator result path and the display pins.

---
 rtl/display_scan_ctrl_if.sv | 25 ++
 rtl/display_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// Bus between the calculator result path and the scan controller.
// The master side supplies values and options; the slave side drives the display pins.
interface display_scan_ctrl_if #(
    parameter int N_DIGITS = 4
);
    logic                    load;
    logic [4*N_DIGITS-1:0]   bcd_in;
    logic [N_DIGITS-1:0]     dp_in;
    logic                    lz_blank;
    logic [3:0]              bcd_out;
    logic [N_DIGITS-1:0]     an;
    logic                    dp;
    logic                    load_ack;
    logic                    frame_tick;

    modport master (
        output load, bcd_in, dp_in, lz_blank,
        input  bcd_out, an, dp, load_ack, frame_tick
    );

    modport slave (
        input  load, bcd_in, dp_in, lz_blank,
        output bcd_out, an, dp, load_ack, frame_tick
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Each slot starts with a blanking gap, and new values are committed only at frame boundaries.
module display_scan_ctrl #(
    parameter int N_DIGITS  = 4,
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                clk,
    input  logic                reset,
    display_scan_ctrl_if.slave  bus
);
    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(N_DIGITS);
    localparam int VW = 4 * N_DIGITS;
    localparam logic [CW-1:0] CNT_MAX  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_MAX  = IW'(N_DIGITS - 1);

    typedef enum logic {BLANK, SHOW} slot_state_t;

    slot_state_t          st, st_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [VW-1:0]        pend_val, pend_val_n, act_val, act_val_n;
    logic [N_DIGITS-1:0]  pend_dp, pend_dp_n, act_dp, act_dp_n;
    logic                 pend_flag, pend_flag_n;
    logic                 frame_end;
    logic [N_DIGITS-1:0]  zero_run;
    logic [3:0]           digit;

    logic [3:0]           bcd_q, bcd_n;
    logic [N_DIGITS-1:0]  an_q, an_n;
    logic                 dp_q, dp_n, ack_q, ack_n, tick_q, tick_n;

    always_comb begin
        frame_end = (cnt == CNT_MAX) && (idx == IDX_MAX);
        cnt_n     = cnt + CW'(1);
        idx_n     = idx;
        if (cnt == CNT_MAX) begin
            cnt_n = '0;
            idx_n = (idx == IDX_MAX) ? '0 : idx + IW'(1);
        end

        st_n = st;
        case (st)
            BLANK:   if (cnt_n == CNT_SHOW) st_n = SHOW;
            SHOW:    if (cnt == CNT_MAX)    st_n = BLANK;
            default: st_n = BLANK;
        endcase

        pend_val_n  = pend_val;
        pend_dp_n   = pend_dp;
        pend_flag_n = pend_flag;
        act_val_n   = act_val;
        act_dp_n    = act_dp;
        ack_n       = 1'b0;
        // A load landing on the boundary edge bypasses pending and wins over an older pending value.
        if (frame_end) begin
            if (bus.load) begin
                act_val_n = bus.bcd_in;
                act_dp_n  = bus.dp_in;
            end else if (pend_flag) begin
                act_val_n = pend_val;
                act_dp_n  = pend_dp;
            end
            ack_n       = bus.load | pend_flag;
            pend_flag_n = 1'b0;
        end else if (bus.load) begin
            pend_val_n  = bus.bcd_in;
            pend_dp_n   = bus.dp_in;
            pend_flag_n = 1'b1;
        end

        // zero_run[i]: digits i..N_DIGITS-1 of the value about to be shown are all zero.
        zero_run = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            zero_run[i] = ((act_val_n >> (4 * i)) == '0);
        end
        digit = 4'(act_val_n >> (4 * idx_n));
        if (bus.lz_blank && (idx_n != '0) && zero_run[idx_n]) digit = 4'hF;

        // Outputs are registered from next-cycle state so they line up with cnt/idx.
        an_n  = '1;
        bcd_n = 4'hF;
        dp_n  = 1'b1;
        if (st_n == SHOW) begin
            an_n[idx_n] = 1'b0;
            bcd_n       = digit;
            dp_n        = ~act_dp_n[idx_n];
        end
        tick_n = (cnt_n == CNT_MAX) && (idx_n == IDX_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= BLANK;
            cnt       <= '0;
            idx       <= '0;
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_flag <= 1'b0;
            act_val   <= '0;
            act_dp    <= '0;
            an_q      <= '1;
            bcd_q     <= 4'hF;
            dp_q      <= 1'b1;
            ack_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            st        <= st_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            pend_val  <= pend_val_n;
            pend_dp   <= pend_dp_n;
            pend_flag <= pend_flag_n;
            act_val   <= act_val_n;
            act_dp    <= act_dp_n;
            an_q      <= an_n;
            bcd_q     <= bcd_n;
            dp_q      <= dp_n;
            ack_q     <= ack_n;
            tick_q    <= tick_n;
        end
    end

    assign bus.an         = an_q;
    assign bus.bcd_out    = bcd_q;
    assign bus.dp         = dp_q;
    assign bus.load_ack   = ack_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios followed by random loads, all checked
// against a cycle-indexed reference model of the scan schedule and commit rules.
module tb_display_scan_ctrl;
    localparam int N  = 4;
    localparam int P  = 8;
    localparam int B  = 2;
    localparam int FR = N * P;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_scan_ctrl_if #(.N_DIGITS(N)) bus();

    display_scan_ctrl #(.N_DIGITS(N), .PRESCALE(P), .BLANK_CYC(B)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int t     = 0;

    logic [15:0] m_act, m_pend;
    logic [3:0]  m_dp, m_pdp;
    logic        m_pf, m_ack, lz_prev;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    // Expected pins for cycle t follow directly from slot arithmetic on t.
    task automatic check_outputs();
        int pos, dig;
        logic [3:0] e_an, e_bcd;
        logic       e_dp;
        pos = (t - 1) % P;
        dig = ((t - 1) / P) % N;
        if (pos < B) begin
            e_an  = 4'hF;
            e_bcd = 4'hF;
            e_dp  = 1'b1;
        end else begin
            e_an  = 4'hF & ~(4'(1) << dig);
            e_bcd = 4'((m_act >> (4 * dig)) & 16'hF);
            if (lz_prev && dig > 0 && (m_act >> (4 * dig)) == 16'h0) e_bcd = 4'hF;
            e_dp  = ~m_dp[dig];
        end
        chk("an",         16'(bus.an),         16'(e_an));
        chk("bcd_out",    16'(bus.bcd_out),    16'(e_bcd));
        chk("dp",         16'(bus.dp),         16'(e_dp));
        chk("load_ack",   16'(bus.load_ack),   16'(m_ack));
        chk("frame_tick", 16'(bus.frame_tick), 16'((t % FR) == 0));
    endtask

    task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] d);
        bus.load   = ld;
        bus.bcd_in = v;
        bus.dp_in  = d;
        @(negedge clk);
        check_outputs();
        m_ack = 1'b0;
        if ((t % FR) == 0) begin
            if (ld) begin
                m_act = v;
                m_dp  = d;
                m_ack = 1'b1;
            end else if (m_pf) begin
                m_act = m_pend;
                m_dp  = m_pdp;
                m_ack = 1'b1;
            end
            m_pf = 1'b0;
        end else if (ld) begin
            m_pend = v;
            m_pdp  = d;
            m_pf   = 1'b1;
        end
        @(posedge clk);
        #1;
        lz_prev  = bus.lz_blank;
        bus.load = 1'b0;
        t++;
    endtask

    task automatic run_to(input int tt);
        while (t < tt) cycle(1'b0, 16'h0, 4'h0);
    endtask

    // Holds reset for three edges; the last held cycle is t=1 once reset drops.
    task automatic do_reset();
        reset    = 1'b1;
        bus.load = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("rst_an",         16'(bus.an),         16'hF);
            chk("rst_bcd_out",    16'(bus.bcd_out),    16'hF);
            chk("rst_dp",         16'(bus.dp),         16'h1);
            chk("rst_load_ack",   16'(bus.load_ack),   16'h0);
            chk("rst_frame_tick", 16'(bus.frame_tick), 16'h0);
        end
        reset  = 1'b0;
        m_act  = '0;
        m_dp   = '0;
        m_pend = '0;
        m_pdp  = '0;
        m_pf   = 1'b0;
        m_ack  = 1'b0;
        @(posedge clk);
        #1;
        lz_prev = bus.lz_blank;
        t = 2;
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.bcd_in   = '0;
        bus.dp_in    = '0;
        bus.lz_blank = 1'b0;

        // Basic load committed at the first frame boundary.
        do_reset();
        run_to(5);
        cycle(1'b1, 16'h1234, 4'h0);
        run_to(65);

        // Two loads before commit: last one wins, single ack.
        do_reset();
        run_to(10);
        cycle(1'b1, 16'h1111, 4'h0);
        run_to(20);
        cycle(1'b1, 16'h2222, 4'h0);
        run_to(65);

        // Load on the frame_tick cycle goes straight to active.
        do_reset();
        run_to(32);
        cycle(1'b1, 16'h9876, 4'h0);
        run_to(65);

        // Leading-zero suppression with a decimal point on a live digit.
        bus.lz_blank = 1'b1;
        do_reset();
        run_to(3);
        cycle(1'b1, 16'h0050, 4'b0010);
        run_to(65);
        bus.lz_blank = 1'b0;
        run_to(97);

        // Reset mid-SHOW with a committed value, then display returns to zeros.
        do_reset();
        run_to(5);
        cycle(1'b1, 16'h1234, 4'hA);
        run_to(45);
        do_reset();
        run_to(40);

        // Random loads, values including non-BCD codes, and toggling suppression.
        repeat (800) begin
            if ($urandom_range(0, 49) == 0) bus.lz_blank = ~bus.lz_blank;
            if ((t % FR) == 0 && $urandom_range(0, 2) == 0)
                cycle(1'b1, 16'($urandom), 4'($urandom));
            else
                cycle(($urandom_range(0, 15) == 0), 16'($urandom_range(0, 255) << (4 * $urandom_range(0, 2))), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
